// File: rtl/fir_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : fir_result_packer
// Purpose  : Quantizes the signed fir_filter result stream. Each sample is
//            rounded half-up, arithmetically shifted right by SHIFT, saturated
//            to OUT_W bits and buffered in a show-ahead FIFO. The FIFO drains
//            downstream on a valid/ready handshake.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous, active-high reset
//            y_in       - signed FIR result (IN_W bits)
//            y_valid    - y_in carries a new sample this cycle
//            q_data     - signed scaled sample at FIFO head (0 when empty)
//            q_valid    - FIFO non-empty
//            q_ready    - downstream accepts q_data this cycle
//            level      - current FIFO occupancy
//            sat_count  - samples clipped by saturation (sticks at FFFF)
//            drop_count - samples lost to a full FIFO (sticks at FFFF)
// Revision : 1.0 - initial release
// ============================================================================
module fir_result_packer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IN_W-1:0]          y_in,
    input  logic                     y_valid,
    output logic [OUT_W-1:0]         q_data,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              sat_count,
    output logic [15:0]              drop_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_DEPTH = (c_AW+1)'(DEPTH);
    // Clamp limits expressed at the widened intermediate width.
    localparam logic signed [IN_W:0] c_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] c_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Stage 1: round, shift, clamp
    // ------------------------------------------------------------------
    // One extra bit of headroom so adding the rounding constant to the most
    // positive input cannot wrap before saturation.
    logic signed [IN_W:0] w_ext;
    logic signed [IN_W:0] w_scaled;
    assign w_ext = {y_in[IN_W-1], y_in};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [IN_W:0] c_HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT-1);
            logic signed [IN_W:0] w_sum;
            assign w_sum    = w_ext + c_HALF;
            assign w_scaled = w_sum >>> SHIFT;
        end else begin : g_noround
            assign w_scaled = w_ext;
        end
    endgenerate

    logic             w_hi;
    logic             w_lo;
    logic [OUT_W-1:0] w_clamped;

    always_comb begin
        w_hi      = (w_scaled > c_MAX);
        w_lo      = (w_scaled < c_MIN);
        w_clamped = w_scaled[OUT_W-1:0];
        if (w_hi) begin
            w_clamped = c_MAX[OUT_W-1:0];
        end else if (w_lo) begin
            w_clamped = c_MIN[OUT_W-1:0];
        end
    end

    logic [OUT_W-1:0] r_s1_data;
    logic             r_s1_valid;
    logic [15:0]      r_sat_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_data   <= '0;
            r_s1_valid  <= 1'b0;
            r_sat_count <= '0;
        end else begin
            r_s1_valid <= y_valid;
            if (y_valid) begin
                r_s1_data <= w_clamped;
                if ((w_hi || w_lo) && (r_sat_count != 16'hFFFF)) begin
                    r_sat_count <= r_sat_count + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: show-ahead FIFO
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_level;
    logic [15:0]      r_drop_count;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full = (r_level == c_DEPTH);
    assign w_pop  = q_valid && q_ready;
    // A pop frees the head slot in the same edge, so a full FIFO still
    // accepts the incoming sample when downstream is draining.
    assign w_push = r_s1_valid && (!w_full || w_pop);
    assign w_drop = r_s1_valid && w_full && !w_pop;

    // Storage carries no reset; the pointers and level define what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_s1_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_level      <= '0;
            r_drop_count <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign q_valid    = (r_level != '0);
    assign q_data     = q_valid ? r_mem[r_rptr] : '0;
    assign level      = r_level;
    assign sat_count  = r_sat_count;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_fir_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_result_packer
// Purpose  : Self-checking bench for fir_result_packer (default parameters).
//            Expected samples are queued as stimulus is driven and compared
//            whenever the bench completes a q_valid/q_ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_result_packer;

    logic        clk;
    logic        reset;
    logic [31:0] y_in;
    logic        y_valid;
    logic [15:0] q_data;
    logic        q_valid;
    logic        q_ready;
    logic [3:0]  level;
    logic [15:0] sat_count;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    int sb[$];

    typedef struct {
        logic [31:0] y;
        int          exp_q;
        int          sat;
    } vec_t;

    vec_t vecs[13];

    fir_result_packer #(
        .IN_W(32), .OUT_W(16), .SHIFT(8), .DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .y_in(y_in), .y_valid(y_valid),
        .q_data(q_data), .q_valid(q_valid), .q_ready(q_ready),
        .level(level), .sat_count(sat_count), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Called at a falling edge: drive inputs, score any handshake that the
    // next rising edge will complete, then advance one full cycle.
    task automatic step(input logic v, input logic [31:0] y, input logic rdy);
        int e;
        y_valid = v;
        y_in    = y;
        q_ready = rdy;
        if (q_valid && q_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output actual=%0d expected=none",
                         longint'($signed(q_data)));
            end else begin
                e = sb.pop_front();
                chk("sb_data", longint'($signed(q_data)), e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    int exp_sat;

    initial begin
        vecs[0]  = '{32'd384,        2,      0};
        vecs[1]  = '{32'd383,        1,      0};
        vecs[2]  = '{-32'sd384,      -1,     0};
        vecs[3]  = '{32'd0,          0,      0};
        vecs[4]  = '{32'd127,        0,      0};
        vecs[5]  = '{32'd128,        1,      0};
        vecs[6]  = '{-32'sd128,      0,      0};
        vecs[7]  = '{-32'sd385,      -2,     0};
        vecs[8]  = '{32'h007FFF7F,   32767,  0};
        vecs[9]  = '{32'hFF800000,   -32768, 0};
        vecs[10] = '{32'h00800000,   32767,  1};
        vecs[11] = '{32'hFF7FFF00,   -32768, 1};
        vecs[12] = '{32'h7FFFFFFF,   32767,  1};

        // ---------------- reset with valid input held ----------------
        reset   = 1'b1;
        y_valid = 1'b1;
        y_in    = 32'd384;
        q_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_q_data", q_data, 0);
        chk("rst_level", level, 0);
        chk("rst_sat", sat_count, 0);
        chk("rst_drop", drop_count, 0);
        reset = 1'b0;

        // ---------------- two-cycle latency ----------------
        step(1'b1, 32'd384, 1'b0);
        chk("lat_edge1_valid", q_valid, 0);
        step(1'b0, 32'd0, 1'b0);
        chk("lat_edge2_valid", q_valid, 1);
        chk("lat_edge2_data", longint'($signed(q_data)), 2);
        chk("lat_edge2_level", level, 1);
        sb.push_back(2);
        step(1'b0, 32'd0, 1'b1);
        chk("lat_drained", level, 0);

        // ---------------- rounding / saturation table ----------------
        exp_sat = 0;
        for (int i = 0; i < 13; i++) begin
            sb.push_back(vecs[i].exp_q);
            exp_sat += vecs[i].sat;
            step(1'b1, vecs[i].y, 1'b1);
        end
        repeat (3) step(1'b0, 32'd0, 1'b1);
        chk("tbl_sat_count", sat_count, exp_sat);
        chk("tbl_level", level, 0);
        chk("tbl_sb_empty", sb.size(), 0);

        // ---------------- backpressure / overflow ----------------
        for (int k = 1; k <= 10; k++) step(1'b1, 32'(256 * k), 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("ovf_level", level, 8);
        chk("ovf_drop", drop_count, 2);
        chk("ovf_q_data_head", longint'($signed(q_data)), 1);
        for (int k = 1; k <= 8; k++) sb.push_back(k);
        for (int k = 1; k <= 8; k++) begin
            chk("ovf_drain_valid", q_valid, 1);
            step(1'b0, 32'd0, 1'b1);
        end
        chk("ovf_level_empty", level, 0);
        chk("ovf_q_valid_empty", q_valid, 0);

        // ---------------- full with simultaneous push/pop ----------------
        for (int k = 1; k <= 21; k++) sb.push_back(100 + k);
        for (int k = 1; k <= 9; k++) step(1'b1, 32'(256 * (100 + k)), 1'b0);
        chk("full_level", level, 8);
        for (int k = 10; k <= 21; k++) begin
            chk("full_stream_valid", q_valid, 1);
            step(1'b1, 32'(256 * (100 + k)), 1'b1);
            chk("full_stream_level", level, 8);
        end
        chk("full_drop_unchanged", drop_count, 2);
        for (int k = 0; k < 9; k++) begin
            chk("full_drain_valid", q_valid, 1);
            step(1'b0, 32'd0, 1'b1);
        end
        chk("full_level_empty", level, 0);
        chk("full_sb_empty", sb.size(), 0);

        // ---------------- asynchronous mid-stream reset ----------------
        for (int k = 1; k <= 5; k++) step(1'b1, 32'(256 * (200 + k)), 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("mid_level_before", level, 5);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_async_q_valid", q_valid, 0);
        chk("mid_async_level", level, 0);
        chk("mid_async_q_data", q_data, 0);
        chk("mid_async_sat", sat_count, 0);
        chk("mid_async_drop", drop_count, 0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'd0, 1'b1);
            chk("mid_no_stale", q_valid, 0);
        end
        sb.push_back(55);
        step(1'b1, 32'(256 * 55), 1'b1);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        chk("mid_fresh_level", level, 0);
        chk("mid_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
